// File: rtl/cic_d_rate_ctrl_pkg.sv
// Shared types and helpers for the cic_d rate-change sequencer.
// Imported by the control block and its sub-modules.
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_LOAD,
        ST_SETTLE
    } cic_state_e;

    localparam int DROP_CNT_DW = 16;

    function automatic logic rate_in_range(
        input logic [63:0] rate,
        input logic [63:0] max
    );
        return (rate != 64'd0) && (rate <= max);
    endfunction

endpackage

// File: rtl/cic_d_rate_ctrl_if.sv
// Rate-request channel between the configuration master
// and the rate sequencer.
interface cic_d_rate_ctrl_if #(
    parameter int RATE_DW = 32
);
    logic [RATE_DW-1:0] cfg_rate_tdata;
    logic               cfg_rate_tvalid;
    logic               cfg_rate_tready;
    logic               cfg_err;

    modport master (
        output cfg_rate_tdata,
        output cfg_rate_tvalid,
        input  cfg_rate_tready,
        input  cfg_err
    );

    modport slave (
        input  cfg_rate_tdata,
        input  cfg_rate_tvalid,
        output cfg_rate_tready,
        output cfg_err
    );
endinterface

// File: rtl/cic_d_rate_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that
// takes priority over the increment.
module cic_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/cic_d_rate_ctrl.sv
// Run-time rate-change sequencer for the variable-rate cic_d:
// flush, load the new rate, then hide the comb transient.
module cic_d_rate_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int INP_DW         = 32,
    parameter int OUT_DW         = 32,
    parameter int RATE_DW        = 32,
    parameter int CIC_R          = 10,
    parameter int CIC_N          = 7,
    parameter int CIC_M          = 1,
    parameter int FLUSH_CYCLES   = 4,
    parameter int SETTLE_OUTPUTS = CIC_N * CIC_M
) (
    input  logic                   clk,
    input  logic                   reset_n,
    cic_d_rate_ctrl_if.slave       cfg,
    input  logic [INP_DW-1:0]      s_axis_in_tdata,
    input  logic                   s_axis_in_tvalid,
    output logic [INP_DW-1:0]      cic_in_tdata,
    output logic                   cic_in_tvalid,
    output logic [RATE_DW-1:0]     cic_rate_tdata,
    output logic                   cic_rate_tvalid,
    output logic                   cic_reset_n,
    input  logic [OUT_DW-1:0]      cic_out_tdata,
    input  logic                   cic_out_tvalid,
    output logic [OUT_DW-1:0]      m_axis_out_tdata,
    output logic                   m_axis_out_tvalid,
    output logic [RATE_DW-1:0]     current_rate,
    output logic                   busy,
    output logic [DROP_CNT_DW-1:0] drop_cnt,
    input  logic                   drop_clr
);
    localparam int FW    = (FLUSH_CYCLES < 2) ? 1
                         : $clog2(FLUSH_CYCLES);
    localparam int FLAST = FLUSH_CYCLES - 1;
    localparam int SW    = (SETTLE_OUTPUTS < 2) ? 1
                         : $clog2(SETTLE_OUTPUTS);
    localparam int SLAST = (SETTLE_OUTPUTS > 0)
                         ? SETTLE_OUTPUTS - 1 : 0;

    cic_state_e         state_q, state_d;
    logic [FW-1:0]      flush_q, flush_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic [RATE_DW-1:0] pend_q, pend_d;
    logic [RATE_DW-1:0] cur_q, cur_d;
    logic               err_q, err_d;
    logic               crst_q;
    logic               hs;
    logic               req_ok;
    logic               drop_inc;

    assign cfg.cfg_rate_tready = (state_q == ST_RUN);
    assign cfg.cfg_err         = err_q;

    assign hs     = cfg.cfg_rate_tvalid
                 && cfg.cfg_rate_tready;
    assign req_ok = rate_in_range(
                        64'(cfg.cfg_rate_tdata),
                        64'(CIC_R));

    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        settle_d = settle_q;
        pend_d   = pend_q;
        cur_d    = cur_q;
        err_d    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (hs && req_ok) begin
                    pend_d  = cfg.cfg_rate_tdata;
                    flush_d = '0;
                    state_d = ST_FLUSH;
                end else if (hs) begin
                    err_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_q == FW'(FLAST)) begin
                    state_d = ST_LOAD;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            ST_LOAD: begin
                cur_d    = pend_q;
                settle_d = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                // the output completing the count is still hidden
                if (SETTLE_OUTPUTS == 0) begin
                    state_d = ST_RUN;
                end else if (cic_out_tvalid) begin
                    if (settle_q == SW'(SLAST)) begin
                        state_d = ST_RUN;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
            end
            default: state_d = ST_SETTLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_SETTLE;
            flush_q  <= '0;
            settle_q <= '0;
            pend_q   <= RATE_DW'(CIC_R);
            cur_q    <= RATE_DW'(CIC_R);
            err_q    <= 1'b0;
            crst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            settle_q <= settle_d;
            pend_q   <= pend_d;
            cur_q    <= cur_d;
            err_q    <= err_d;
            crst_q   <= (state_d != ST_FLUSH);
        end
    end

    assign cic_in_tdata      = s_axis_in_tdata;
    assign cic_in_tvalid     = s_axis_in_tvalid
                            && ((state_q == ST_RUN)
                             || (state_q == ST_SETTLE));
    assign cic_rate_tdata    = pend_q;
    assign cic_rate_tvalid   = (state_q == ST_LOAD);
    assign cic_reset_n       = crst_q;
    assign m_axis_out_tdata  = cic_out_tdata;
    assign m_axis_out_tvalid = cic_out_tvalid
                            && (state_q == ST_RUN);
    assign current_rate      = cur_q;
    assign busy              = (state_q != ST_RUN);

    assign drop_inc = s_axis_in_tvalid && !cic_in_tvalid;

    cic_sat_counter #(
        .W (DROP_CNT_DW)
    ) u_drop_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (drop_clr),
        .inc_i   (drop_inc),
        .cnt_o   (drop_cnt)
    );
endmodule

// File: tb/tb_cic_d_rate_ctrl.sv
// Bench for cic_d_rate_ctrl: directed vectors, corner sequences
// and random traffic against a countdown reference model.
module tb_cic_d_rate_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] s_data;
    logic        s_vld;
    logic [31:0] cin_data;
    logic        cin_vld;
    logic [31:0] rate_data;
    logic        rate_vld;
    logic        crst_n;
    logic [31:0] co_data;
    logic        co_vld;
    logic [31:0] m_data;
    logic        m_vld;
    logic [31:0] cur_rate;
    logic        busy;
    logic [15:0] drop_cnt;
    logic        drop_clr;
    logic        sclr;
    logic        sinc;
    logic [3:0]  scnt;

    int total = 0;
    int bad   = 0;

    int          m_flush;
    bit          m_load;
    int          m_settle;
    bit          m_fresh;
    logic [31:0] m_rate;
    logic [31:0] m_pend;
    bit          m_err;
    int          m_drop;

    typedef struct {
        logic [31:0] rate;
        bit          err;
        logic [31:0] cur;
    } vec_t;

    always #5 clk = ~clk;

    cic_d_rate_ctrl_if #(.RATE_DW(32)) cfg ();

    cic_d_rate_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cfg               (cfg),
        .s_axis_in_tdata   (s_data),
        .s_axis_in_tvalid  (s_vld),
        .cic_in_tdata      (cin_data),
        .cic_in_tvalid     (cin_vld),
        .cic_rate_tdata    (rate_data),
        .cic_rate_tvalid   (rate_vld),
        .cic_reset_n       (crst_n),
        .cic_out_tdata     (co_data),
        .cic_out_tvalid    (co_vld),
        .m_axis_out_tdata  (m_data),
        .m_axis_out_tvalid (m_vld),
        .current_rate      (cur_rate),
        .busy              (busy),
        .drop_cnt          (drop_cnt),
        .drop_clr          (drop_clr)
    );

    cic_sat_counter #(.W(4)) u_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (sclr),
        .inc_i   (sinc),
        .cnt_o   (scnt)
    );

    task automatic chk(string nm, logic [63:0] act,
                       logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic mreset();
        m_fresh  = 1'b1;
        m_flush  = 0;
        m_load   = 1'b0;
        m_settle = 7;
        m_rate   = 32'd10;
        m_pend   = 32'd10;
        m_err    = 1'b0;
        m_drop   = 0;
    endtask

    task automatic mcheck();
        logic       run;
        logic       quiet;
        logic [6:0] ef;
        logic [6:0] af;
        run   = (m_flush == 0) && !m_load && (m_settle == 0);
        quiet = (m_flush != 0) || m_load;
        ef = {run, m_err, s_vld && !quiet, m_load,
              (m_flush == 0) && !m_fresh, co_vld && run, !run};
        af = {cfg.cfg_rate_tready, cfg.cfg_err, cin_vld,
              rate_vld, crst_n, m_vld, busy};
        chk("flags", 64'(af), 64'(ef));
        chk("rate_data", 64'(rate_data), 64'(m_pend));
        chk("cur_rate", 64'(cur_rate), 64'(m_rate));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("in_data", 64'(cin_data), 64'(s_data));
        chk("out_data", 64'(m_data), 64'(co_data));
    endtask

    task automatic mupdate();
        logic        run;
        logic        quiet;
        logic [31:0] d;
        run   = (m_flush == 0) && !m_load && (m_settle == 0);
        quiet = (m_flush != 0) || m_load;
        d     = cfg.cfg_rate_tdata;
        m_fresh = 1'b0;
        m_err   = 1'b0;
        if (drop_clr) m_drop = 0;
        else if (s_vld && quiet && m_drop < 65535) m_drop++;
        if (run && cfg.cfg_rate_tvalid) begin
            if (d >= 1 && d <= 10) begin
                m_pend  = d;
                m_flush = 4;
            end else begin
                m_err = 1'b1;
            end
        end else if (m_flush > 0) begin
            m_flush--;
            if (m_flush == 0) m_load = 1'b1;
        end else if (m_load) begin
            m_load   = 1'b0;
            m_rate   = m_pend;
            m_settle = 7;
        end else if (m_settle > 0 && co_vld) begin
            m_settle--;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mcheck();
        @(posedge clk);
        if (reset_n) mupdate();
        #1;
    endtask

    task automatic do_settle();
        for (int i = 0; i < 8; i++) begin
            co_vld  = 1'b1;
            co_data = $urandom;
            #1;
            chk("settle_mvld", 64'(m_vld), 64'(i == 7));
            if (i == 7) chk("settle_busy", 64'(busy), 64'd0);
            cyc();
        end
        co_vld = 1'b0;
    endtask

    task automatic request(logic [31:0] r);
        cfg.cfg_rate_tdata  = r;
        cfg.cfg_rate_tvalid = 1'b1;
        #1;
        chk("req_ready", 64'(cfg.cfg_rate_tready), 64'd1);
        cyc();
        cfg.cfg_rate_tvalid = 1'b0;
    endtask

    initial begin
        vec_t tbl[6];
        int   hs;
        int   hs_at;
        tbl[0] = '{32'd10, 1'b0, 32'd10};
        tbl[1] = '{32'd0, 1'b1, 32'd10};
        tbl[2] = '{32'd11, 1'b1, 32'd10};
        tbl[3] = '{32'hFFFF_FFFF, 1'b1, 32'd10};
        tbl[4] = '{32'd10, 1'b0, 32'd10};
        tbl[5] = '{32'd1, 1'b0, 32'd1};

        reset_n = 1'b0;
        s_data = '0; s_vld = 1'b0;
        co_data = '0; co_vld = 1'b0;
        drop_clr = 1'b0; sclr = 1'b0; sinc = 1'b0;
        cfg.cfg_rate_tdata  = '0;
        cfg.cfg_rate_tvalid = 1'b0;
        mreset();
        repeat (3) cyc();
        reset_n = 1'b1;
        #1;
        chk("rst_rate", 64'(cur_rate), 64'd10);
        chk("rst_busy", 64'(busy), 64'd1);
        cyc();
        do_settle();

        // rate change to 5 with inputs streaming
        s_vld = 1'b1;
        request(32'd5);
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("flush_rstn", 64'(crst_n), 64'd0);
            cyc();
        end
        #1;
        chk("load_vld", 64'(rate_vld), 64'd1);
        chk("load_data", 64'(rate_data), 64'd5);
        chk("load_rstn", 64'(crst_n), 64'd1);
        chk("load_cur", 64'(cur_rate), 64'd10);
        cyc();
        chk("new_cur", 64'(cur_rate), 64'd5);
        chk("drop5", 64'(drop_cnt), 64'd5);
        do_settle();

        for (int i = 0; i < 6; i++) begin
            request(tbl[i].rate);
            chk("tbl_err", 64'(cfg.cfg_err), 64'(tbl[i].err));
            chk("tbl_busy", 64'(busy), 64'(!tbl[i].err));
            if (!tbl[i].err) begin
                repeat (5) cyc();
                do_settle();
            end else begin
                chk("tbl_rstn", 64'(crst_n), 64'd1);
                cyc();
            end
            chk("tbl_cur", 64'(cur_rate), 64'(tbl[i].cur));
        end

        // request held through the whole sequence
        request(32'd3);
        cfg.cfg_rate_tdata  = 32'd7;
        cfg.cfg_rate_tvalid = 1'b1;
        repeat (5) cyc();
        chk("held_cur3", 64'(cur_rate), 64'd3);
        hs = 0;
        hs_at = -1;
        for (int i = 0; i < 30 && hs == 0; i++) begin
            co_vld = 1'b1;
            #1;
            if (cfg.cfg_rate_tready) begin
                hs++;
                hs_at = i;
            end
            cyc();
        end
        cfg.cfg_rate_tvalid = 1'b0;
        co_vld = 1'b0;
        chk("held_hs", 64'(hs), 64'd1);
        chk("held_at", 64'(hs_at), 64'd7);
        repeat (5) cyc();
        do_settle();
        chk("held_cur7", 64'(cur_rate), 64'd7);

        // clear wins over a same-cycle drop
        request(32'd2);
        cyc();
        drop_clr = 1'b1;
        cyc();
        drop_clr = 1'b0;
        chk("clr_prio", 64'(drop_cnt), 64'd0);
        repeat (3) cyc();
        chk("drop3", 64'(drop_cnt), 64'd3);
        do_settle();

        // reset in the second flush cycle
        request(32'd4);
        cyc();
        reset_n = 1'b0;
        #1;
        chk("mr_rstn", 64'(crst_n), 64'd0);
        chk("mr_cur", 64'(cur_rate), 64'd10);
        chk("mr_rdata", 64'(rate_data), 64'd10);
        chk("mr_rvld", 64'(rate_vld), 64'd0);
        chk("mr_busy", 64'(busy), 64'd1);
        chk("mr_drop", 64'(drop_cnt), 64'd0);
        mreset();
        repeat (2) cyc();
        reset_n = 1'b1;
        cyc();
        chk("mr_settle", 64'(busy), 64'd1);
        chk("mr_rstn_up", 64'(crst_n), 64'd1);
        do_settle();
        chk("mr_cur_end", 64'(cur_rate), 64'd10);

        for (int i = 0; i < 3000; i++) begin
            s_vld    = 1'($urandom);
            s_data   = $urandom;
            co_vld   = 1'($urandom);
            co_data  = $urandom;
            drop_clr = ($urandom_range(0, 31) == 0);
            cfg.cfg_rate_tvalid = ($urandom_range(0, 2) == 0);
            cfg.cfg_rate_tdata  = ($urandom_range(0, 3) == 0)
                                ? $urandom
                                : 32'($urandom_range(0, 12));
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                mreset();
                cyc();
                reset_n = 1'b1;
            end
            cyc();
        end
        s_vld = 1'b0; co_vld = 1'b0; drop_clr = 1'b0;
        cfg.cfg_rate_tvalid = 1'b0;

        sinc = 1'b1;
        repeat (3) cyc();
        chk("sat_3", 64'(scnt), 64'd3);
        repeat (17) cyc();
        chk("sat_max", 64'(scnt), 64'd15);
        sclr = 1'b1;
        cyc();
        chk("sat_clr", 64'(scnt), 64'd0);
        sclr = 1'b0;
        sinc = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
